sync_wbuf_fifo: RTL and testbench
=================================

# sync_wbuf_fifo

Synchronous FIFO on a single-port RAM, built as the write-side counterpart of the prefetching read FIFO. RAM reads have priority over RAM writes. Incoming words are absorbed by a 4-entry write-staging queue, which drains into RAM in cycles with no read. A 2-entry output stage, fed from RAM with 1-cycle read latency, presents data on a valid/ready stream.

## Interface
- DATA_WIDTH, 8, width of in_data/out_data
- FIFO_DEPTH, 256, RAM entries and total capacity; power of two, ≥ 4
- LB_FIFO_DEPTH, $clog2(FIFO_DEPTH), address width
- clk  in  1  clock; all state updates on posedge
- rstn  in  1  reset, synchronous, active-low
- in_data  in  DATA_WIDTH  write data
- in_valid  in  1  write request
- in_ready  out  1  write accepted when in_valid & in_ready
- out_data  out  DATA_WIDTH  head of FIFO, driven from output-stage head register
- out_valid  out  1  output stage non-empty
- out_ready  in  1  pop when out_valid & out_ready
- clear  in  1  synchronous flush, same effect as reset
- count  out  LB_FIFO_DEPTH+1  total words held: staging + RAM + in-flight read + output stage

## Operation
- Data order: output stage ← RAM ← staging ← input. Words leave in acceptance order.
- Counters:
  - st_cnt: staging, 0..4
  - mem_cnt: RAM, 0..FIFO_DEPTH
  - rd_inflight: 0..1
  - ob_cnt: output stage, 0..2
- RAM pointers: waddr, raddr, each LB_FIFO_DEPTH bits, wrapping modulo FIFO_DEPTH.
- in_ready = (st_cnt < 4) & (count < FIFO_DEPTH). Combinational from registers only, never from in_valid or out_ready.
- Per-cycle RAM arbitration:
  - Read issues when mem_cnt > 0, ob_cnt + rd_inflight < 2, and st_cnt != 4. Read increments raddr, decrements mem_cnt, sets rd_inflight for next cycle.
  - Drain issues when no read issues and st_cnt > 0. Drain writes the staging head to RAM[waddr], increments waddr and mem_cnt, pops staging.
  - When staging is full, drain wins over read (starvation guard).
- When rd_inflight = 1, RAM dout is pushed into the output stage at the next edge. Read issue rules guarantee space.
- count is updated from accept (+1) and pop (−1). Accept and pop in the same cycle leave count unchanged.
- clear, or rstn low, at an edge:
  - all counters, pointers and rd_inflight go to 0
  - any accept or pop in that cycle is discarded
  - RAM contents are not cleared

## Timing
- Reset and clear values, effective after the edge: out_valid=0, count=0, in_ready=1. out_data is don't-care while out_valid=0.
- Latency without bypass: word accepted at edge E0, drained at E1, read issued at E2, captured at E3. out_valid is high in the cycle after E3, i.e. 3 cycles.
- Sustained simultaneous streaming throughput is below 1 word/cycle; the starvation guard steals one read slot each time staging fills. Pure fill (out_ready=0) accepts 1 word/cycle until count=FIFO_DEPTH.
- Full: count = FIFO_DEPTH gives in_ready=0. A pop in that cycle does not raise in_ready in the same cycle; it rises the next cycle.
- Empty: out_valid=0 whenever ob_cnt=0, regardless of RAM or staging content.
- Pointer wrap: after FIFO_DEPTH drains, waddr returns to 0 with no gap or duplicate word.
- out_data and out_valid are registered outputs; no combinational path from in_* to out_*.

## Configuration
- SYNC_WBUF_FIFO_BYPASS_EN defined:
  - If st_cnt=0, mem_cnt=0, rd_inflight=0 and ob_cnt < 2 in the accept cycle, the accepted word is written directly into the output stage, skipping staging and RAM.
  - out_valid rises the cycle after acceptance (1-cycle latency).
- Undefined: no bypass; every word takes the 3-cycle staging/RAM path; behaviour otherwise identical.

## Test plan
- Reset, then idle 5 cycles → out_valid=0, count=0, in_ready=1 throughout.
- Write 0x01..0x05 back-to-back with out_ready=0, then out_ready=1 → reads return 0x01..0x05 in order; count steps 5→0.
- Single write 0xA5 into empty FIFO → out_valid rises 3 cycles later, or 1 cycle with SYNC_WBUF_FIFO_BYPASS_EN; out_data=0xA5.
- FIFO_DEPTH=16: write 0..15 with out_ready=0 → in_ready=0 at count=16. Pop one, write 16 → in_ready returns next cycle; after 3 full wraps, output sequence is strictly incrementing.
- Continuous in_valid=1 and out_ready=1 for 200 cycles → no loss or reorder; count stays ≤ 6; in_ready drops only when staging is full.
- Assert clear with count=10 and in_valid=1 → next cycle count=0, out_valid=0; the word offered in the clear cycle is never output.

Source files
------------

// File: rtl/sync_wbuf_fifo.sv
// Synchronous FIFO on a single-port RAM with a 4-entry write-staging queue and a 2-entry output stage.
// Optional SYNC_WBUF_FIFO_BYPASS_EN lets a word enter the output stage directly when everything upstream is empty.
module sync_wbuf_fifo #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH    = 256,
    parameter int unsigned LB_FIFO_DEPTH = $clog2(FIFO_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     clear,
    output logic [LB_FIFO_DEPTH:0]   count
);

    localparam int unsigned ST_DEPTH = 4;
    localparam int unsigned ST_AW    = 2;
    localparam int unsigned ST_CW    = 3;
    localparam int unsigned OB_CW    = 2;
    localparam int unsigned CW       = LB_FIFO_DEPTH + 1;

    // Staging queue
    logic [DATA_WIDTH-1:0]    r_st_data [ST_DEPTH];
    logic [ST_AW-1:0]         r_st_wptr;
    logic [ST_AW-1:0]         r_st_rptr;
    logic [ST_CW-1:0]         r_st_cnt;

    // Single-port RAM and its bookkeeping
    logic [DATA_WIDTH-1:0]    r_ram [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    r_ram_dout;
    logic [LB_FIFO_DEPTH-1:0] r_waddr;
    logic [LB_FIFO_DEPTH-1:0] r_raddr;
    logic [CW-1:0]            r_mem_cnt;
    logic                     r_rd_inflight;

    // Output stage, entry 0 is the head
    logic [DATA_WIDTH-1:0]    r_ob_data [2];
    logic [OB_CW-1:0]         r_ob_cnt;
    logic                     r_out_valid;

    logic [CW-1:0]            r_count;

    logic                     w_accept;
    logic                     w_pop;
    logic                     w_st_full;
    logic [OB_CW-1:0]         w_ob_occ;
    logic                     w_rd_issue;
    logic                     w_drain;
    logic                     w_bypass;
    logic                     w_st_push;
    logic                     w_ob_push;
    logic [DATA_WIDTH-1:0]    w_ob_push_data;
    logic [DATA_WIDTH-1:0]    w_ob_nxt [2];
    logic [OB_CW-1:0]         w_ob_cnt_nxt;
    logic [CW-1:0]            w_count_nxt;

    assign in_ready  = (r_st_cnt < ST_CW'(ST_DEPTH)) && (r_count < CW'(FIFO_DEPTH));
    assign out_valid = r_out_valid;
    assign out_data  = r_ob_data[0];
    assign count     = r_count;

    assign w_accept  = in_valid & in_ready;
    assign w_pop     = r_out_valid & out_ready;
    assign w_st_full = (r_st_cnt == ST_CW'(ST_DEPTH));
    assign w_ob_occ  = r_ob_cnt + OB_CW'(r_rd_inflight);

    // RAM arbitration: reads first, except a full staging queue forces a drain
    assign w_rd_issue = (r_mem_cnt != '0) && (w_ob_occ < OB_CW'(2)) && !w_st_full;
    assign w_drain    = !w_rd_issue && (r_st_cnt != '0);

`ifdef SYNC_WBUF_FIFO_BYPASS_EN
    assign w_bypass = w_accept && (r_st_cnt == '0) && (r_mem_cnt == '0)
                   && !r_rd_inflight && (r_ob_cnt < OB_CW'(2));
`else
    assign w_bypass = 1'b0;
`endif

    assign w_st_push      = w_accept & ~w_bypass;
    assign w_ob_push      = r_rd_inflight | w_bypass;
    assign w_ob_push_data = r_rd_inflight ? r_ram_dout : in_data;

    // Output-stage next state: shift on pop, then append the incoming word
    always_comb begin
        w_ob_nxt[0]  = r_ob_data[0];
        w_ob_nxt[1]  = r_ob_data[1];
        w_ob_cnt_nxt = r_ob_cnt;
        if (w_pop) begin
            w_ob_nxt[0]  = r_ob_data[1];
            w_ob_cnt_nxt = r_ob_cnt - OB_CW'(1);
        end
        if (w_ob_push) begin
            w_ob_nxt[w_ob_cnt_nxt[0]] = w_ob_push_data;
            w_ob_cnt_nxt              = w_ob_cnt_nxt + OB_CW'(1);
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_accept, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Control state; clear behaves exactly like reset
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            r_st_wptr     <= '0;
            r_st_rptr     <= '0;
            r_st_cnt      <= '0;
            r_waddr       <= '0;
            r_raddr       <= '0;
            r_mem_cnt     <= '0;
            r_rd_inflight <= 1'b0;
            r_ob_cnt      <= '0;
            r_out_valid   <= 1'b0;
            r_count       <= '0;
        end else begin
            if (w_st_push) begin
                r_st_wptr <= r_st_wptr + ST_AW'(1);
            end
            if (w_drain) begin
                r_st_rptr <= r_st_rptr + ST_AW'(1);
                r_waddr   <= r_waddr + LB_FIFO_DEPTH'(1);
            end
            case ({w_st_push, w_drain})
                2'b10:   r_st_cnt <= r_st_cnt + ST_CW'(1);
                2'b01:   r_st_cnt <= r_st_cnt - ST_CW'(1);
                default: r_st_cnt <= r_st_cnt;
            endcase
            if (w_rd_issue) begin
                r_raddr <= r_raddr + LB_FIFO_DEPTH'(1);
            end
            case ({w_drain, w_rd_issue})
                2'b10:   r_mem_cnt <= r_mem_cnt + CW'(1);
                2'b01:   r_mem_cnt <= r_mem_cnt - CW'(1);
                default: r_mem_cnt <= r_mem_cnt;
            endcase
            r_rd_inflight <= w_rd_issue;
            r_ob_cnt      <= w_ob_cnt_nxt;
            r_out_valid   <= (w_ob_cnt_nxt != '0);
            r_count       <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_st_push) begin
            r_st_data[r_st_wptr] <= in_data;
        end
    end

    // RAM array is never reset; only one of read/drain fires per cycle
    always_ff @(posedge clk) begin
        if (w_drain) begin
            r_ram[r_waddr] <= r_st_data[r_st_rptr];
        end
        if (w_rd_issue) begin
            r_ram_dout <= r_ram[r_raddr];
        end
    end

    always_ff @(posedge clk) begin
        r_ob_data[0] <= w_ob_nxt[0];
        r_ob_data[1] <= w_ob_nxt[1];
    end

endmodule

// File: tb/tb_sync_wbuf_fifo.sv
// Self-checking bench for sync_wbuf_fifo (FIFO_DEPTH=16) using a scoreboard queue and a vector table.
module tb_sync_wbuf_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);
`ifdef SYNC_WBUF_FIFO_BYPASS_EN
    localparam int unsigned EXP_LAT = 0;
`else
    localparam int unsigned EXP_LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          clear;
    logic [AW:0]   count;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] sb [$];

    typedef struct {
        logic          vld;
        logic [DW-1:0] dat;
        logic          rdy;
        int unsigned   exp_cnt;
        logic          exp_ird;
        logic          chk_ov;
        logic          exp_ov;
    } vec_t;

    vec_t vecs [8];

    sync_wbuf_fifo #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .LB_FIFO_DEPTH (AW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clear     (clear),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: score the handshakes about to happen, step the edge, check generic invariants
    task automatic tick(output bit acc);
        bit            pop;
        logic [DW-1:0] e;
        acc = in_valid && in_ready && !clear;
        pop = out_valid && out_ready && !clear;
        if (pop) begin
            chk("pop_has_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e));
            end
        end
        if (clear) sb.delete();
        else if (acc) sb.push_back(in_data);
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(sb.size()));
        if (sb.size() == 0) chk("out_valid_empty", 32'(out_valid), 32'd0);
        if (32'(count) == DEPTH) chk("in_ready_full", 32'(in_ready), 32'd0);
    endtask

    task automatic drain(input int budget);
        bit acc;
        int i;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        i = 0;
        while (sb.size() != 0 && i < budget) begin
            tick(acc);
            i++;
        end
        chk("drain_done", 32'(sb.size()), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        bit            acc;
        int            n;
        int            lat;
        int            acc_cnt;
        logic [DW-1:0] d;

        vecs[0] = '{1'b1, 8'h01, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h02, 1'b0, 2, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h03, 1'b0, 3, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h04, 1'b0, 4, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 8'h05, 1'b0, 5, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 5, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 5, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 5, 1'b1, 1'b1, 1'b1};

        rstn      = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_in_ready", 32'(in_ready), 32'd1);
        end

        // Table: 0x01..0x05 with out_ready low, then hold
        for (int i = 0; i < 8; i++) begin
            in_valid  = vecs[i].vld;
            in_data   = vecs[i].dat;
            out_ready = vecs[i].rdy;
            tick(acc);
            chk("vec_count", 32'(count), vecs[i].exp_cnt);
            chk("vec_in_ready", 32'(in_ready), 32'(vecs[i].exp_ird));
            if (vecs[i].chk_ov) chk("vec_out_valid", 32'(out_valid), 32'(vecs[i].exp_ov));
        end
        drain(40);

        // Single-word latency
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick(acc);
        chk("lat_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 12) begin
            tick(acc);
            lat++;
        end
        chk("latency", 32'(lat), EXP_LAT);
        chk("lat_data", 32'(out_data), 32'hA5);
        drain(10);

        // Fill to full at one word per cycle
        n = 0;
        for (int i = 0; i < 40 && n < int'(DEPTH); i++) begin
            in_valid = 1'b1;
            in_data  = DW'(n);
            tick(acc);
            chk("fill_accept", 32'(acc), 32'd1);
            if (acc) n++;
        end
        chk("full_count", 32'(count), DEPTH);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_data   = DW'(n);
        out_ready = 1'b1;
        tick(acc);
        chk("full_pop_no_accept", 32'(acc), 32'd0);
        out_ready = 1'b0;
        chk("full_ready_returns", 32'(in_ready), 32'd1);
        tick(acc);
        chk("full_accept_after", 32'(acc), 32'd1);
        if (acc) n++;

        // Random traffic across several pointer wraps
        for (int i = 0; i < 2000 && n < int'(4 * DEPTH); i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'(n);
            out_ready = 1'($urandom_range(0, 1));
            tick(acc);
            if (acc) n++;
        end
        chk("wrap_progress", 32'(n), 4 * DEPTH);
        drain(100);

        // Simultaneous streaming
        d         = 8'h80;
        acc_cnt   = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_data = d;
            tick(acc);
            if (acc) begin
                d = d + 8'd1;
                acc_cnt++;
            end
            chk("stream_count_le6", 32'(count <= 6), 32'd1);
        end
        chk("stream_throughput", 32'(acc_cnt >= 60), 32'd1);
        drain(40);

        // Clear with 10 words held and a word offered in the same cycle
        out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 30 && n < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(8'h40 + n);
            tick(acc);
            if (acc) n++;
        end
        chk("clr_pre_count", 32'(count), 32'd10);
        in_data = 8'hEE;
        clear   = 1'b1;
        tick(acc);
        clear = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(acc);
            chk("clr_stays_empty", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b1;
        in_data  = 8'h33;
        tick(acc);
        chk("post_clr_accept", 32'(acc), 32'd1);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
